fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage between the PC register and the ID stage of the pipelined MIPS CPU. It takes the current PC, issues a request to instruction memory over a request/grant plus read-valid handshake, and pulses the PC register's write enable when a request is accepted. It returns the fetched word into the IF/ID output register, and holds at most one extra word in a skid buffer while decode stalls. A branch/jump flush discards everything in flight and buffered.

## Interface
- RESET_PC, 32'h00400000: value of id_pc after reset; matches the PC register reset value.
- NOP_INSTR, 32'h00000000: value driven on id_instr whenever id_valid is 0.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- pc_in  input  32  current PC from the PC register.
- pc_advance  output  1  write enable to the PC register; high for exactly the cycles where imem_req && imem_gnt.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; equals pc_in.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; exactly one response per granted request, at least 1 cycle after grant.
- imem_rdata  input  32  instruction word.
- flush  input  1  branch/jump redirect from EX; kill all fetched and in-flight words.
- id_ready  input  1  decode consumes id_* this cycle (inverse of the ID stall).
- id_valid  output  1  id_* holds a valid instruction.
- id_instr  output  32  instruction to decode.
- id_pc  output  32  address of id_instr.
- id_pc_plus4  output  32  id_pc + 4, combinational, modulo 2^32.

## Operation
- Four-state FSM:
  - S_REQ: ready to issue a request.
  - S_WAIT: one request is outstanding.
  - S_FULL: the skid buffer is occupied and fetch is halted.
  - S_DROP: the outstanding response is to be discarded.
- imem_req = (state == S_REQ) && !flush && rst.
- imem_addr = pc_in at all times.
- S_REQ:
  - On grant, latch req_pc = pc_in and go to S_WAIT.
  - Without grant, stay in S_REQ.
- S_WAIT, no rvalid:
  - flush → S_DROP.
  - Otherwise stay in S_WAIT.
- S_WAIT, rvalid:
  - flush → discard the word and go to S_REQ.
  - Output slot free (!id_valid || id_ready) → load the output register with {imem_rdata, req_pc} and go to S_REQ.
  - Output slot full (id_valid && !id_ready) → store the word and req_pc in the skid buffer and go to S_FULL.
- S_FULL:
  - id_ready → move the skid buffer into the output register and go to S_REQ.
  - flush → clear the skid buffer and go to S_REQ.
- S_DROP: on rvalid, discard the word and go to S_REQ. flush in this state has no extra effect.
- Output register:
  - flush → id_valid = 0 next cycle.
  - Otherwise, new load → id_valid = 1.
  - Otherwise, id_ready && id_valid → id_valid = 0.
  - Otherwise hold.
- id_instr = NOP_INSTR when !id_valid, otherwise the stored word.
- Priority: flush > load > consume.
- Grant and PC: no request is issued while a response is outstanding, so pc_advance never pulses twice for one PC. PC next-value selection (+4 or branch target) is the PC register's concern.

## Timing
- Reset (rst low), asynchronous:
  - state = S_REQ.
  - id_valid = 0, id_instr = NOP_INSTR, id_pc = RESET_PC, id_pc_plus4 = RESET_PC + 4.
  - Skid buffer empty.
  - imem_req = 0 and pc_advance = 0 while rst is low.
- Reset mid-operation abandons any outstanding response. Memory is reset by the same signal.
- Latency: with grant in cycle N and rvalid in cycle N+1, id_valid rises at edge N+2. The next request issues in cycle N+2.
- Throughput: steady state is 1 instruction per 2 cycles with 1-cycle memory; slower memory adds its extra latency cycle-for-cycle.
- flush in cycle N:
  - id_valid = 0 from edge N+1.
  - No request is issued in cycle N.
  - The first post-flush request uses pc_in in cycle N+1 or later (the redirected PC).
- Boundary cases:
  - id_pc = 32'hFFFFFFFC → id_pc_plus4 = 0.
  - Grant and flush in the same cycle cannot occur, because imem_req is gated by flush.

## Test plan
- Reset/idle:
  - Stimulus: hold rst low, then release with pc_in = 0x00400000, imem_gnt = 1, and rvalid one cycle after grant.
  - Required: imem_req = 0 during reset; id_valid rises 2 edges after the first grant with id_pc = 0x00400000 and id_pc_plus4 = 0x00400004.
  - Required: pc_advance pulses once per fetch.
- Stall with skid:
  - Stimulus: id_ready = 0 while two words arrive (0x20080001 then 0x20090002).
  - Required: the first is held on id_*, the second goes to the skid buffer, imem_req stays 0 in S_FULL.
  - Required: after id_ready rises, the words are consumed in order with no loss and no duplication.
- Flush in S_WAIT:
  - Stimulus: grant at PC 0x00400008, flush in the next cycle, rvalid 3 cycles later.
  - Required: the response is discarded (S_DROP); the next request uses the redirect PC (e.g. 0x00400040); id_valid = 0 until that word returns.
- Flush in S_FULL:
  - Stimulus: output and skid both valid, assert flush.
  - Required: id_valid = 0 on the next edge, the skid buffer is cleared, and a request issues the following cycle.
- Slow memory:
  - Stimulus: imem_gnt low for 3 cycles, then rvalid 4 cycles after grant.
  - Required: imem_addr is stable while waiting, pc_advance pulses only on the grant cycle, and the instruction is delivered with the correct id_pc.
- Wrap:
  - Stimulus: fetch at pc_in = 0xFFFFFFFC.
  - Required: id_pc_plus4 = 0x00000000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/grant/rvalid
// handshake plus the IF/ID output register valid/ready handshake.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  id_ready,
        output id_valid, id_instr, id_pc, id_pc_plus4
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output id_ready,
        input  id_valid, id_instr, id_pc, id_pc_plus4
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID output
// register and a one-entry skid buffer, with branch/jump flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic req;
    logic slot_free;
    logic wait_load;
    logic skid_load;
    logic full_load;

    // Handshake outputs and load strobes derived from the current state
    always_comb begin
        req        = (state_q == S_REQ) && !flush && rst;
        pc_advance = req && bus.imem_gnt;
        slot_free  = !id_valid_q || bus.id_ready;
        wait_load  = (state_q == S_WAIT) && bus.imem_rvalid
                     && !flush && slot_free;
        skid_load  = (state_q == S_WAIT) && bus.imem_rvalid
                     && !flush && !slot_free;
        full_load  = (state_q == S_FULL) && bus.id_ready && !flush;
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_in;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_valid_q ? id_instr_q : NOP_INSTR;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_q + 32'd4;

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (pc_advance) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (flush || slot_free) state_d = S_REQ;
                    else                    state_d = S_FULL;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_FULL: begin
                if (flush || bus.id_ready) state_d = S_REQ;
            end
            S_DROP: begin
                if (bus.imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Datapath: request PC capture, output register and skid buffer
    always_comb begin
        req_pc_d     = req_pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (pc_advance) req_pc_d = pc_in;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (wait_load) begin
            id_valid_d = 1'b1;
            id_instr_d = bus.imem_rdata;
            id_pc_d    = req_pc_q;
        end else if (full_load) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_instr_q;
            id_pc_d    = skid_pc_q;
        end else if (bus.id_ready && id_valid_q) begin
            id_valid_d = 1'b0;
        end
        if (skid_load) begin
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = req_pc_q;
        end else if (flush && state_q == S_FULL) begin
            skid_instr_d = '0;
            skid_pc_d    = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_REQ;
        else      state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc_q     <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            req_pc_q     <= req_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a
// randomized run against an in-order fetch scoreboard.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        flush;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .flush      (flush),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    rsp_t        mem_q[$];
    ent_t        exp_q[$];
    logic [31:0] imem[logic [31:0]];
    int          mem_lat;
    int          cyc;
    int          nchk;
    int          npass;

    logic        s_req, s_adv, s_v, s_rv;
    logic [31:0] s_addr, s_instr, s_pc, s_p4;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        if (imem.exists(pc)) return imem[pc];
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive inputs, act as memory, snapshot pre-edge
    // outputs, then return at the following falling edge.
    task automatic drive(input logic [31:0] pc, input logic gnt,
                         input logic fl, input logic rdy);
        pc_in        = pc;
        bus.imem_gnt = gnt;
        flush        = fl;
        bus.id_ready = rdy;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_q[0].data;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        s_req   = bus.imem_req;
        s_adv   = pc_advance;
        s_addr  = bus.imem_addr;
        s_v     = bus.id_valid;
        s_instr = bus.id_instr;
        s_pc    = bus.id_pc;
        s_p4    = bus.id_pc_plus4;
        s_rv    = bus.imem_rvalid;
        if (!rst) begin
            mem_q.delete();
        end else begin
            if (s_rv) void'(mem_q.pop_front());
            if (s_adv) mem_q.push_back('{cyc + mem_lat, word_of(pc)});
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        mem_q.delete();
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] pc;
        rst = 1'b0;
        mem_lat = 1;
        repeat (3) begin
            drive(32'h0040_0000, 1'b1, 1'b0, 1'b1);
            nchk++; if (s_req !== 1'b0) $display("FAIL rst_req: got %b want 0", s_req); else npass++;
            nchk++; if (s_adv !== 1'b0) $display("FAIL rst_adv: got %b want 0", s_adv); else npass++;
            nchk++; if (s_v !== 1'b0) $display("FAIL rst_valid: got %b want 0", s_v); else npass++;
            nchk++; if (s_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", s_instr); else npass++;
            nchk++; if (s_pc !== 32'h0040_0000) $display("FAIL rst_pc: got %h want 00400000", s_pc); else npass++;
            nchk++; if (s_p4 !== 32'h0040_0004) $display("FAIL rst_pc4: got %h want 00400004", s_p4); else npass++;
        end
        rst = 1'b1;
        drive(32'h0040_0000, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_adv !== 1'b1) $display("FAIL first_grant: got %b want 1", s_adv); else npass++;
        nchk++; if (s_addr !== 32'h0040_0000) $display("FAIL first_addr: got %h want 00400000", s_addr); else npass++;
        drive(32'h0040_0004, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_req !== 1'b0) $display("FAIL wait_req: got %b want 0", s_req); else npass++;
        nchk++; if (bus.id_valid !== 1'b1) $display("FAIL lat_valid: got %b want 1", bus.id_valid); else npass++;
        nchk++; if (bus.id_pc !== 32'h0040_0000) $display("FAIL lat_pc: got %h want 00400000", bus.id_pc); else npass++;
        nchk++; if (bus.id_pc_plus4 !== 32'h0040_0004) $display("FAIL lat_pc4: got %h want 00400004", bus.id_pc_plus4); else npass++;
        nchk++; if (bus.id_instr !== word_of(32'h0040_0000)) $display("FAIL lat_instr: got %h want %h", bus.id_instr, word_of(32'h0040_0000)); else npass++;
        n = 0;
        pc = 32'h0040_0004;
        for (int i = 0; i < 6; i++) begin
            drive(pc, 1'b1, 1'b0, 1'b1);
            if (i == 0) begin
                nchk++; if (s_adv !== 1'b1) $display("FAIL next_req: got %b want 1", s_adv); else npass++;
            end
            if (s_adv) begin
                n++;
                pc = pc + 32'd4;
            end
        end
        nchk++; if (n != 3) $display("FAIL adv_count: got %0d want 3", n); else npass++;
    endtask

    task automatic test_stall_skid();
        do_reset();
        mem_lat = 1;
        imem[32'h0040_0000] = 32'h2008_0001;
        imem[32'h0040_0004] = 32'h2009_0002;
        drive(32'h0040_0000, 1'b1, 1'b0, 1'b0);
        nchk++; if (s_adv !== 1'b1) $display("FAIL skid_g1: got %b want 1", s_adv); else npass++;
        drive(32'h0040_0004, 1'b1, 1'b0, 1'b0);
        nchk++; if (bus.id_instr !== 32'h2008_0001) $display("FAIL skid_w1: got %h want 20080001", bus.id_instr); else npass++;
        drive(32'h0040_0004, 1'b1, 1'b0, 1'b0);
        nchk++; if (s_adv !== 1'b1) $display("FAIL skid_g2: got %b want 1", s_adv); else npass++;
        drive(32'h0040_0008, 1'b1, 1'b0, 1'b0);
        nchk++; if (bus.id_instr !== 32'h2008_0001) $display("FAIL skid_hold: got %h want 20080001", bus.id_instr); else npass++;
        nchk++; if (bus.id_pc !== 32'h0040_0000) $display("FAIL skid_hold_pc: got %h want 00400000", bus.id_pc); else npass++;
        repeat (2) begin
            drive(32'h0040_0008, 1'b1, 1'b0, 1'b0);
            nchk++; if (s_req !== 1'b0) $display("FAIL full_req: got %b want 0", s_req); else npass++;
            nchk++; if (bus.id_instr !== 32'h2008_0001) $display("FAIL full_hold: got %h want 20080001", bus.id_instr); else npass++;
        end
        drive(32'h0040_0008, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_req !== 1'b0) $display("FAIL drain_req: got %b want 0", s_req); else npass++;
        nchk++; if (s_instr !== 32'h2008_0001) $display("FAIL drain_w1: got %h want 20080001", s_instr); else npass++;
        nchk++; if (bus.id_instr !== 32'h2009_0002) $display("FAIL drain_w2: got %h want 20090002", bus.id_instr); else npass++;
        nchk++; if (bus.id_pc !== 32'h0040_0004) $display("FAIL drain_pc2: got %h want 00400004", bus.id_pc); else npass++;
        drive(32'h0040_0008, 1'b0, 1'b0, 1'b1);
        nchk++; if (s_req !== 1'b1) $display("FAIL resume_req: got %b want 1", s_req); else npass++;
        nchk++; if (bus.id_valid !== 1'b0) $display("FAIL no_dup: got %b want 0", bus.id_valid); else npass++;
        imem.delete();
    endtask

    task automatic test_flush_wait();
        do_reset();
        mem_lat = 4;
        drive(32'h0040_0008, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_adv !== 1'b1) $display("FAIL fw_grant: got %b want 1", s_adv); else npass++;
        drive(32'h0040_0008, 1'b1, 1'b1, 1'b1);
        nchk++; if (s_req !== 1'b0) $display("FAIL fw_flush_req: got %b want 0", s_req); else npass++;
        repeat (2) begin
            drive(32'h0040_0040, 1'b1, 1'b0, 1'b1);
            nchk++; if (s_req !== 1'b0) $display("FAIL fw_drop_req: got %b want 0", s_req); else npass++;
            nchk++; if (bus.id_valid !== 1'b0) $display("FAIL fw_drop_valid: got %b want 0", bus.id_valid); else npass++;
        end
        drive(32'h0040_0040, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_rv !== 1'b1 || s_req !== 1'b0) $display("FAIL fw_discard: got rv=%b req=%b want rv=1 req=0", s_rv, s_req); else npass++;
        nchk++; if (bus.id_valid !== 1'b0) $display("FAIL fw_discard_valid: got %b want 0", bus.id_valid); else npass++;
        mem_lat = 1;
        drive(32'h0040_0040, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_adv !== 1'b1) $display("FAIL fw_redirect: got %b want 1", s_adv); else npass++;
        nchk++; if (s_addr !== 32'h0040_0040) $display("FAIL fw_addr: got %h want 00400040", s_addr); else npass++;
        drive(32'h0040_0044, 1'b0, 1'b0, 1'b1);
        nchk++; if (bus.id_valid !== 1'b1) $display("FAIL fw_valid: got %b want 1", bus.id_valid); else npass++;
        nchk++; if (bus.id_pc !== 32'h0040_0040) $display("FAIL fw_pc: got %h want 00400040", bus.id_pc); else npass++;
        nchk++; if (bus.id_instr !== word_of(32'h0040_0040)) $display("FAIL fw_instr: got %h want %h", bus.id_instr, word_of(32'h0040_0040)); else npass++;
    endtask

    task automatic test_flush_full();
        do_reset();
        mem_lat = 1;
        drive(32'h0040_0000, 1'b1, 1'b0, 1'b0);
        drive(32'h0040_0004, 1'b1, 1'b0, 1'b0);
        drive(32'h0040_0004, 1'b1, 1'b0, 1'b0);
        drive(32'h0040_0008, 1'b1, 1'b0, 1'b0);
        nchk++; if (bus.id_valid !== 1'b1) $display("FAIL ff_setup: got %b want 1", bus.id_valid); else npass++;
        drive(32'h0040_0100, 1'b1, 1'b1, 1'b0);
        nchk++; if (s_req !== 1'b0) $display("FAIL ff_req: got %b want 0", s_req); else npass++;
        nchk++; if (bus.id_valid !== 1'b0) $display("FAIL ff_valid: got %b want 0", bus.id_valid); else npass++;
        nchk++; if (bus.id_instr !== 32'h0) $display("FAIL ff_nop: got %h want 0", bus.id_instr); else npass++;
        drive(32'h0040_0100, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_adv !== 1'b1) $display("FAIL ff_next_req: got %b want 1", s_adv); else npass++;
        drive(32'h0040_0104, 1'b0, 1'b0, 1'b1);
        nchk++; if (bus.id_pc !== 32'h0040_0100) $display("FAIL ff_pc: got %h want 00400100", bus.id_pc); else npass++;
        drive(32'h0040_0104, 1'b0, 1'b0, 1'b1);
        nchk++; if (bus.id_valid !== 1'b0) $display("FAIL ff_skid_clr: got %b want 0", bus.id_valid); else npass++;
    endtask

    task automatic test_slow_mem();
        do_reset();
        mem_lat = 4;
        repeat (3) begin
            drive(32'h0040_0200, 1'b0, 1'b0, 1'b1);
            nchk++; if (s_req !== 1'b1 || s_adv !== 1'b0) $display("FAIL sm_nogrant: got req=%b adv=%b want 1 0", s_req, s_adv); else npass++;
            nchk++; if (s_addr !== 32'h0040_0200) $display("FAIL sm_addr: got %h want 00400200", s_addr); else npass++;
        end
        drive(32'h0040_0200, 1'b1, 1'b0, 1'b1);
        nchk++; if (s_adv !== 1'b1) $display("FAIL sm_grant: got %b want 1", s_adv); else npass++;
        repeat (3) begin
            drive(32'h0040_0204, 1'b1, 1'b0, 1'b1);
            nchk++; if (s_adv !== 1'b0) $display("FAIL sm_wait_adv: got %b want 0", s_adv); else npass++;
            nchk++; if (bus.id_valid !== 1'b0) $display("FAIL sm_wait_valid: got %b want 0", bus.id_valid); else npass++;
        end
        drive(32'h0040_0204, 1'b1, 1'b0, 1'b1);
        nchk++; if (bus.id_valid !== 1'b1) $display("FAIL sm_valid: got %b want 1", bus.id_valid); else npass++;
        nchk++; if (bus.id_pc !== 32'h0040_0200) $display("FAIL sm_pc: got %h want 00400200", bus.id_pc); else npass++;
        nchk++; if (bus.id_instr !== word_of(32'h0040_0200)) $display("FAIL sm_instr: got %h want %h", bus.id_instr, word_of(32'h0040_0200)); else npass++;
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat = 1;
        drive(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
        drive(32'h0000_0000, 1'b0, 1'b0, 1'b1);
        nchk++; if (bus.id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffc", bus.id_pc); else npass++;
        nchk++; if (bus.id_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h want 0", bus.id_pc_plus4); else npass++;
    endtask

    task automatic test_random();
        int          outstanding;
        int          delivered;
        logic [31:0] pc;
        logic        g, f, r;
        ent_t        e;
        do_reset();
        exp_q.delete();
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                drive($urandom & 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
                rst = 1'b1;
                exp_q.delete();
                continue;
            end
            pc = $urandom & 32'hFFFF_FFFC;
            g = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 9) < 6);
            mem_lat = $urandom_range(1, 4);
            outstanding = mem_q.size();
            drive(pc, g, f, r);
            nchk++; if (s_addr !== pc) $display("FAIL rnd_addr: got %h want %h", s_addr, pc); else npass++;
            nchk++; if (s_adv !== (s_req && g)) $display("FAIL rnd_adv: got %b req=%b gnt=%b", s_adv, s_req, g); else npass++;
            if (outstanding > 0 || f) begin
                nchk++; if (s_req !== 1'b0) $display("FAIL rnd_req_busy: got %b want 0", s_req); else npass++;
            end
            nchk++; if (s_p4 !== s_pc + 32'd4) $display("FAIL rnd_pc4: got %h want %h", s_p4, s_pc + 32'd4); else npass++;
            if (!s_v) begin
                nchk++; if (s_instr !== 32'h0) $display("FAIL rnd_nop: got %h want 0", s_instr); else npass++;
            end
            if (s_v && r) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_extra: got pc=%h instr=%h want none", s_pc, s_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (s_pc !== e.pc || s_instr !== e.instr)
                        $display("FAIL rnd_order: got %h/%h want %h/%h", s_pc, s_instr, e.pc, e.instr);
                    else npass++;
                end
                delivered++;
            end
            if (f) exp_q.delete();
            if (s_adv) exp_q.push_back('{pc, word_of(pc)});
            nchk++; if (exp_q.size() > 3) $display("FAIL rnd_depth: got %0d want <=3", exp_q.size()); else npass++;
        end
        nchk++; if (delivered < 100) $display("FAIL rnd_progress: got %0d want >=100", delivered); else npass++;
    endtask

    initial begin
        rst             = 1'b0;
        pc_in           = 32'h0;
        flush           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.id_ready    = 1'b0;
        mem_lat         = 1;
        cyc             = 0;
        nchk            = 0;
        npass           = 0;
        @(negedge clk);
        test_reset();
        test_stall_skid();
        test_flush_wait();
        test_flush_full();
        test_slow_mem();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
